// File: rtl/cascaded_bank_ram.sv
// 32x8 RAM built from four 8x8 banks, registered read-first port, saturating write counter.
// Optional power-up clear sequence enabled by defining CASCADED_BANK_RAM_CLEAR_EN.
module cascaded_bank_ram #(
    parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic [4:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    input  logic [4:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    output logic       busy_o,
    output logic [5:0] wr_count_o
);

    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned BANK_DEPTH = 8;

    function automatic logic [5:0] sat_inc(input logic [5:0] value);
        if (value == 6'd63) begin
            return value;
        end else begin
            return value + 6'd1;
        end
    endfunction

    logic       busy_s;
    logic       wr_ready_s;
    logic       clr_we_s;
    logic [4:0] clr_addr_s;
    logic       wr_accept_s;
    logic       rd_fire_s;
    logic       mem_we_s;
    logic [4:0] mem_addr_s;
    logic [7:0] mem_data_s;
    logic [NUM_BANKS-1:0] bank_we_s;
    logic [7:0] bank_rd_s [NUM_BANKS];

    logic [7:0] rd_data_q,  rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic [5:0] wr_count_q, wr_count_d;

`ifdef CASCADED_BANK_RAM_CLEAR_EN
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] ctr_q,   ctr_d;

    // Clear FSM state and sweep counter; reset restarts the sweep at address 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            ctr_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // Clear FSM next state: one location per cycle, leave after location 31.
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        clr_we_s = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we_s = 1'b1;
                if (ctr_q == 5'd31) begin
                    state_d = ST_IDLE;
                    ctr_d   = 5'd0;
                end else begin
                    ctr_d   = ctr_q + 5'd1;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                ctr_d   = 5'd0;
            end
        endcase
    end

    assign busy_s     = (state_q == ST_CLEAR);
    assign clr_addr_s = ctr_q;
`else
    assign busy_s     = 1'b0;
    assign clr_we_s   = 1'b0;
    assign clr_addr_s = 5'd0;
`endif

    assign wr_ready_s  = ~busy_s;
    assign wr_accept_s = wr_valid_i & wr_ready_s;
    assign rd_fire_s   = rd_en_i & ~busy_s;

    // Clear and user writes are mutually exclusive; reset never writes the array.
    assign mem_we_s   = ~rst_i & (clr_we_s | wr_accept_s);
    assign mem_addr_s = clr_we_s ? clr_addr_s  : wr_addr_i;
    assign mem_data_s = clr_we_s ? CLEAR_VALUE : wr_data_i;

    // Bank select decode from the upper address bits.
    always_comb begin
        bank_we_s = {NUM_BANKS{1'b0}};
        if (mem_we_s) begin
            bank_we_s[mem_addr_s[4:3]] = 1'b1;
        end else begin
            bank_we_s = {NUM_BANKS{1'b0}};
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [7:0] mem_q [BANK_DEPTH];

        // Per-bank storage, written only when its bank is selected.
        always_ff @(posedge clk_i) begin
            if (bank_we_s[b]) begin
                mem_q[mem_addr_s[2:0]] <= mem_data_s;
            end
        end

        assign bank_rd_s[b] = mem_q[rd_addr_i[2:0]];
    end

    // Output next state: the array is sampled before this edge's write lands.
    always_comb begin
        rd_valid_d = rd_fire_s;
        if (rd_fire_s) begin
            rd_data_d = bank_rd_s[rd_addr_i[4:3]];
        end else begin
            rd_data_d = rd_data_q;
        end
        if (wr_accept_s) begin
            wr_count_d = sat_inc(wr_count_q);
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Registered read port and write counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            wr_count_q <= 6'd0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_ready_o = wr_ready_s;
    assign busy_o     = busy_s;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_cascaded_bank_ram.sv
// Scoreboard bench for cascaded_bank_ram; runs in both the default and the
// CASCADED_BANK_RAM_CLEAR_EN builds.
module tb_cascaded_bank_ram;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [4:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       rd_en_i;
    logic [4:0] rd_addr_i;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       busy_o;
    logic [5:0] wr_count_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] exp_data_q [$];
    int         exp_cyc_q  [$];

    cascaded_bank_ram #(.CLEAR_VALUE(8'h00)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .rd_en_i    (rd_en_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .busy_o     (busy_o),
        .wr_count_o (wr_count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid_o pulse must match the oldest expected read and its latency.
    always @(negedge clk_i) begin
        if (rd_valid_o === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got data %0h with no read outstanding", rd_data_o);
            end else begin
                logic [7:0] ed;
                int         ec;
                ed = exp_data_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("rd_data", {24'd0, rd_data_o}, {24'd0, ed});
                check("rd_latency", cyc, ec);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [7:0] exp);
        rd_en_i   = 1'b1;
        rd_addr_i = a;
        exp_data_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 1);
        tick();
        rd_en_i = 1'b0;
    endtask

    task automatic hold_reset(input int n);
        rst_i = 1'b1;
        repeat (n) tick();
        rst_i = 1'b0;
    endtask

    // Count busy cycles after reset release, optionally poking writes/reads at address 3.
    task automatic measure_clear(input bit poke, output int n);
        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            wr_valid_i = poke && (n >= 5) && (n < 12);
            wr_addr_i  = 5'd3;
            wr_data_i  = 8'hFF;
            rd_en_i    = poke && (n == 8);
            rd_addr_i  = 5'd3;
            tick();
            n++;
        end
        wr_valid_i = 1'b0;
        rd_en_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_i      = 1'b1;
        wr_valid_i = 1'b0;
        wr_addr_i  = 5'd0;
        wr_data_i  = 8'h00;
        rd_en_i    = 1'b0;
        rd_addr_i  = 5'd0;
        repeat (3) tick();

`ifdef CASCADED_BANK_RAM_CLEAR_EN
        check("reset_busy", {31'd0, busy_o}, 32'd1);
        check("reset_wr_ready", {31'd0, wr_ready_o}, 32'd0);
        rst_i = 1'b0;
        check("clear_busy", {31'd0, busy_o}, 32'd1);
        check("clear_wr_ready", {31'd0, wr_ready_o}, 32'd0);
        measure_clear(1'b1, n);
        check("clear_cycles", n, 32'd32);
`else
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_wr_ready", {31'd0, wr_ready_o}, 32'd1);
        rst_i = 1'b0;
        for (int a = 0; a < 32; a++) do_write(a[4:0], 8'h00);
        hold_reset(2);
`endif
        check("idle_busy", {31'd0, busy_o}, 32'd0);
        check("idle_wr_ready", {31'd0, wr_ready_o}, 32'd1);
        check("reset_rd_data", {24'd0, rd_data_o}, 32'h00);
        check("reset_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        check("reset_wr_count", {26'd0, wr_count_o}, 32'd0);

        do_read(5'd21, 8'h00);
        do_read(5'd3, 8'h00);
        check("count_after_busy_writes", {26'd0, wr_count_o}, 32'd0);

        do_write(5'd9, 8'hA5);
        check("count_one", {26'd0, wr_count_o}, 32'd1);
        do_read(5'd9, 8'hA5);
        do_read(5'd1, 8'h00);
        do_read(5'd17, 8'h00);
        do_read(5'd25, 8'h00);

        hold_reset(2);
`ifdef CASCADED_BANK_RAM_CLEAR_EN
        measure_clear(1'b0, n);
        check("clear2_cycles", n, 32'd32);
`endif
        for (int a = 0; a < 32; a++) do_write(a[4:0], {3'd0, a[4:0]} ^ 8'h3C);
        check("count_sweep", {26'd0, wr_count_o}, 32'd32);
        for (int a = 0; a < 32; a++) do_read(a[4:0], {3'd0, a[4:0]} ^ 8'h3C);

        do_write(5'd30, 8'h11);
        wr_valid_i = 1'b1;
        wr_addr_i  = 5'd30;
        wr_data_i  = 8'h22;
        do_read(5'd30, 8'h11);
        wr_valid_i = 1'b0;
        do_read(5'd30, 8'h22);
        check("count_34", {26'd0, wr_count_o}, 32'd34);

        for (int i = 0; i < 29; i++) do_write(5'd0, 8'h77);
        check("count_63", {26'd0, wr_count_o}, 32'd63);
        do_write(5'd0, 8'h78);
        do_write(5'd0, 8'h79);
        check("count_saturated", {26'd0, wr_count_o}, 32'd63);
        do_read(5'd0, 8'h79);

`ifdef CASCADED_BANK_RAM_CLEAR_EN
        hold_reset(2);
        repeat (10) tick();
        check("midclear_busy_before", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        check("midclear_busy_in_reset", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b0;
        measure_clear(1'b0, n);
        check("midclear_cycles", n, 32'd32);
        do_read(5'd31, 8'h00);
        do_read(5'd20, 8'h00);
`endif

        repeat (4) tick();
        check("scoreboard_drained", exp_data_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
